// File: rtl/i2c_bus_mon.sv
// I2C pad front end: sync + deglitch SCL/SDA, bus strobes, busy/timeout/arbitration, open-drain pad enables.
// Latency: raw pad edge to scl_i/sda_i is SYNC_STG + filt_len + 1 cycles; strobes align with that change.
// Backpressure: none; a pure observer that samples the pads every cycle and never stalls.
module i2c_bus_mon #(
  parameter int SYNC_STG = 2,
  parameter int FILT_W   = 4,
  parameter int TO_W     = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cr_en,
  input  logic [FILT_W-1:0] filt_len,
  input  logic [TO_W-1:0]   to_val,
  input  logic              mst_active,
  input  logic              scl_pad_i,
  input  logic              sda_pad_i,
  output logic              scl_pad_oe,
  output logic              sda_pad_oe,
  input  logic              scl_o,
  input  logic              sda_o,
  output logic              scl_i,
  output logic              sda_i,
  output logic              scl_rising,
  output logic              scl_faling,
  output logic              sta,
  output logic              sto,
  output logic              bus_busy,
  output logic              bus_timeout,
  output logic              arb_lost
);

  logic [SYNC_STG-1:0] r_scl_sync, r_sda_sync;
  logic                r_scl_filt, r_sda_filt;
  logic [FILT_W-1:0]   r_scl_cnt, r_sda_cnt;
  logic [TO_W-1:0]     r_to_cnt;
  logic                r_busy;
  logic                r_rise, r_fall, r_sta, r_sto, r_to, r_arb;
  logic                r_scl_oe, r_sda_oe;

  logic w_scl_s, w_sda_s;
  logic w_scl_take, w_sda_take;
  logic w_scl_nxt, w_sda_nxt;
  logic w_rise, w_fall, w_sta, w_sto;
  logic w_to_run, w_to_hit, w_arb;

  assign w_scl_s = r_scl_sync[SYNC_STG-1];
  assign w_sda_s = r_sda_sync[SYNC_STG-1];

  // A line is accepted once it has differed from the filtered value for filt_len+1 samples.
  assign w_scl_take = (w_scl_s != r_scl_filt) && (r_scl_cnt == filt_len);
  assign w_sda_take = (w_sda_s != r_sda_filt) && (r_sda_cnt == filt_len);
  assign w_scl_nxt  = w_scl_take ? w_scl_s : r_scl_filt;
  assign w_sda_nxt  = w_sda_take ? w_sda_s : r_sda_filt;

  // Edge/condition detection on the filtered lines; START/STOP need SCL stable high across the change.
  assign w_rise = cr_en &  w_scl_nxt & ~r_scl_filt;
  assign w_fall = cr_en & ~w_scl_nxt &  r_scl_filt;
  assign w_sta  = cr_en & r_scl_filt & w_scl_nxt &  r_sda_filt & ~w_sda_nxt;
  assign w_sto  = cr_en & r_scl_filt & w_scl_nxt & ~r_sda_filt &  w_sda_nxt;

  // Timeout fires on the cycle the low-count reaches to_val; the counter then parks there.
  assign w_to_run = cr_en & r_busy & ~r_scl_filt & (to_val != '0) & (r_to_cnt != to_val);
  assign w_to_hit = w_to_run & (r_to_cnt == to_val - 1'b1);

  // Released SDA (sda_o = 1) seen low at an SCL rise means another master won.
  assign w_arb = w_rise & mst_active & r_busy & sda_o & ~w_sda_nxt;

  // Pad synchronisers, free-running regardless of cr_en.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STG-2:0], scl_pad_i};
      r_sda_sync <= {r_sda_sync[SYNC_STG-2:0], sda_pad_i};
    end
  end

  // SCL glitch filter: count disagreeing samples, restart whenever the line agrees again.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_scl_filt <= 1'b1;
      r_scl_cnt  <= '0;
    end else if (w_scl_s == r_scl_filt) begin
      r_scl_cnt  <= '0;
    end else if (w_scl_take) begin
      r_scl_filt <= w_scl_s;
      r_scl_cnt  <= '0;
    end else begin
      r_scl_cnt  <= r_scl_cnt + 1'b1;
    end
  end

  // SDA glitch filter, identical to the SCL one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sda_filt <= 1'b1;
      r_sda_cnt  <= '0;
    end else if (w_sda_s == r_sda_filt) begin
      r_sda_cnt  <= '0;
    end else if (w_sda_take) begin
      r_sda_filt <= w_sda_s;
      r_sda_cnt  <= '0;
    end else begin
      r_sda_cnt  <= r_sda_cnt + 1'b1;
    end
  end

  // SCL-low timeout counter; holds at to_val until SCL goes high so it pulses once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_to_cnt <= '0;
    end else if (!cr_en || (to_val == '0) || r_scl_filt) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt == to_val) begin
      r_to_cnt <= r_to_cnt;
    end else if (r_busy) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  // Bus-busy level: START sets (repeated START keeps it set), STOP or timeout clears.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy <= 1'b0;
    end else if (!cr_en) begin
      r_busy <= 1'b0;
    end else if (w_sta) begin
      r_busy <= 1'b1;
    end else if (w_sto || w_to_hit) begin
      r_busy <= 1'b0;
    end
  end

  // Registered strobes and open-drain pad enables.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
      r_sta    <= 1'b0;
      r_sto    <= 1'b0;
      r_to     <= 1'b0;
      r_arb    <= 1'b0;
      r_scl_oe <= 1'b0;
      r_sda_oe <= 1'b0;
    end else begin
      r_rise   <= w_rise;
      r_fall   <= w_fall;
      r_sta    <= w_sta;
      r_sto    <= w_sto;
      r_to     <= w_to_hit;
      r_arb    <= w_arb;
      r_scl_oe <= cr_en & ~scl_o;
      r_sda_oe <= cr_en & ~sda_o;
    end
  end

  assign scl_i       = r_scl_filt;
  assign sda_i       = r_sda_filt;
  assign scl_rising  = r_rise;
  assign scl_faling  = r_fall;
  assign sta         = r_sta;
  assign sto         = r_sto;
  assign bus_busy    = r_busy;
  assign bus_timeout = r_to;
  assign arb_lost    = r_arb;
  assign scl_pad_oe  = r_scl_oe;
  assign sda_pad_oe  = r_sda_oe;

endmodule

// File: tb/tb_i2c_bus_mon.sv
// Bench for i2c_bus_mon: directed bus waveforms with a per-cycle reference model and literal spot checks.
// Latency: model predicts outputs after every rising clock edge; compared 4 ns later.
// Backpressure: not applicable; the design only observes and drives pads.
module tb_i2c_bus_mon;
  localparam int SYNC_STG = 2;
  localparam int FILT_W   = 4;
  localparam int TO_W     = 16;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              cr_en = 1'b1;
  logic [FILT_W-1:0] filt_len = 4'd3;
  logic [TO_W-1:0]   to_val = '0;
  logic              mst_active = 1'b0;
  logic              scl_pad_i = 1'b1;
  logic              sda_pad_i = 1'b1;
  logic              scl_o = 1'b0;
  logic              sda_o = 1'b0;
  logic scl_pad_oe, sda_pad_oe, scl_i, sda_i, scl_rising, scl_faling;
  logic sta, sto, bus_busy, bus_timeout, arb_lost;

  i2c_bus_mon #(.SYNC_STG(SYNC_STG), .FILT_W(FILT_W), .TO_W(TO_W)) dut (
    .clk(clk), .rstn(rstn), .cr_en(cr_en), .filt_len(filt_len), .to_val(to_val),
    .mst_active(mst_active), .scl_pad_i(scl_pad_i), .sda_pad_i(sda_pad_i),
    .scl_pad_oe(scl_pad_oe), .sda_pad_oe(sda_pad_oe), .scl_o(scl_o), .sda_o(sda_o),
    .scl_i(scl_i), .sda_i(sda_i), .scl_rising(scl_rising), .scl_faling(scl_faling),
    .sta(sta), .sto(sto), .bus_busy(bus_busy), .bus_timeout(bus_timeout), .arb_lost(arb_lost)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_set = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Raw pad sample history, newest in bit 0.
  logic [31:0] hs, hd;
  logic m_scl, m_sda, m_busy;
  int   lowrun;
  logic e_rise, e_fall, e_sta, e_sto, e_to, e_arb, e_soe, e_doe;

  // The filtered line takes value v once the last filt_len+1 synchronised samples all equal v.
  function automatic logic fnext(input logic cur, input logic [31:0] h);
    logic v;
    v = h[SYNC_STG];
    if (v == cur) return cur;
    for (int k = 0; k <= int'(filt_len); k++)
      if (h[SYNC_STG + k] != v) return cur;
    return v;
  endfunction

  task automatic model_reset();
    hs = '1; hd = '1;
    m_scl = 1'b1; m_sda = 1'b1; m_busy = 1'b0; lowrun = 0;
    e_rise = 0; e_fall = 0; e_sta = 0; e_sto = 0; e_to = 0; e_arb = 0; e_soe = 0; e_doe = 0;
  endtask

  task automatic model_step();
    logic ns, nd, rise, fall, st, sp, cond;
    hs = {hs[30:0], scl_pad_i};
    hd = {hd[30:0], sda_pad_i};
    ns = fnext(m_scl, hs);
    nd = fnext(m_sda, hd);
    rise = ns & ~m_scl;
    fall = ~ns & m_scl;
    st   = m_scl & ns & m_sda & ~nd;
    sp   = m_scl & ns & ~m_sda & nd;
    cond = cr_en && m_busy && !m_scl && (to_val != 0);
    lowrun = cond ? lowrun + 1 : 0;
    e_to   = cond && (lowrun == int'(to_val));
    e_arb  = cr_en & mst_active & m_busy & sda_o & ~nd & rise;
    e_rise = cr_en & rise;
    e_fall = cr_en & fall;
    e_sta  = cr_en & st;
    e_sto  = cr_en & sp;
    if (!cr_en) m_busy = 1'b0;
    else if (st) m_busy = 1'b1;
    else if (sp || e_to) m_busy = 1'b0;
    e_soe = cr_en & ~scl_o;
    e_doe = cr_en & ~sda_o;
    m_scl = ns;
    m_sda = nd;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else model_step();
    end
  end

  // ---------------- compare + event recording ----------------
  int n_rise, n_fall, n_sta, n_sto, n_to, n_arb, n_sclf, n_sdaf, n_busy;
  int c_rise, c_sta, c_sdaf, c_sclf, c_to, c_arb;
  logic p_scl = 1'b1, p_sda = 1'b1;

  task automatic clr();
    n_rise = 0; n_fall = 0; n_sta = 0; n_sto = 0; n_to = 0; n_arb = 0;
    n_sclf = 0; n_sdaf = 0; n_busy = 0;
    c_rise = -1; c_sta = -1; c_sdaf = -1; c_sclf = -1; c_to = -1; c_arb = -1;
  endtask

  initial begin
    clr();
    forever begin
      @(posedge clk);
      cyc++;
      #4;
      chk1("scl_i", scl_i, m_scl);
      chk1("sda_i", sda_i, m_sda);
      chk1("scl_rising", scl_rising, e_rise);
      chk1("scl_faling", scl_faling, e_fall);
      chk1("sta", sta, e_sta);
      chk1("sto", sto, e_sto);
      chk1("bus_busy", bus_busy, m_busy);
      chk1("bus_timeout", bus_timeout, e_to);
      chk1("arb_lost", arb_lost, e_arb);
      chk1("scl_pad_oe", scl_pad_oe, e_soe);
      chk1("sda_pad_oe", sda_pad_oe, e_doe);
      if (scl_rising)  begin n_rise++; c_rise = cyc; end
      if (scl_faling)  n_fall++;
      if (sta)         begin n_sta++; c_sta = cyc; end
      if (sto)         n_sto++;
      if (bus_timeout) begin n_to++; c_to = cyc; end
      if (arb_lost)    begin n_arb++; c_arb = cyc; end
      if (bus_busy)    n_busy++;
      if (p_scl && !scl_i) begin n_sclf++; c_sclf = cyc; end
      if (p_sda && !sda_i) begin n_sdaf++; c_sdaf = cyc; end
      p_scl = scl_i;
      p_sda = sda_i;
    end
  end

  // ---------------- stimulus ----------------
  // Apply pad levels at a falling edge and hold them for n rising edges.
  task automatic drive(input logic s, input logic d, input int n);
    @(negedge clk);
    scl_pad_i = s;
    sda_pad_i = d;
    t_set = cyc;
    repeat (n) @(posedge clk);
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int t0;
    logic [8:0] bits;
    // Reset: pads released even though the core asks to pull both lines.
    repeat (3) @(negedge clk);
    chk1("rst scl_i", scl_i, 1'b1);
    chk1("rst sda_i", sda_i, 1'b1);
    chk1("rst bus_busy", bus_busy, 1'b0);
    chk1("rst scl_pad_oe", scl_pad_oe, 1'b0);
    chk1("rst sda_pad_oe", sda_pad_oe, 1'b0);
    rstn = 1'b1;
    @(posedge clk); #4;
    chk1("oe after rst scl", scl_pad_oe, 1'b1);
    chk1("oe after rst sda", sda_pad_oe, 1'b1);
    @(negedge clk);
    scl_o = 1'b1; sda_o = 1'b1;
    repeat (4) @(negedge clk);

    // Glitch rejection with filt_len = 3: 3 cycles rejected, 4 accepted 6 cycles later.
    clr();
    drive(1, 0, 3);
    drive(1, 1, 12);
    settle();
    chkn("glitch3 sda falls", n_sdaf, 0);
    chkn("glitch3 sta", n_sta, 0);
    clr();
    drive(1, 0, 4);
    t0 = t_set;
    drive(1, 0, 6);
    settle();
    chkn("glitch4 sda_i latency", c_sdaf - t0, 6);
    chkn("glitch4 sta latency", c_sta - t0, 6);
    chkn("glitch4 sta count", n_sta, 1);
    chk1("glitch4 busy", bus_busy, 1'b1);
    drive(1, 1, 10);
    settle();
    chkn("glitch4 sto count", n_sto, 1);
    chk1("glitch4 idle", bus_busy, 1'b0);

    // START, 9 SCL clocks (last bit ACK = 0), STOP.
    clr();
    bits = 9'b1010_0101_0;
    drive(1, 0, 8);
    for (int i = 8; i >= 0; i--) begin
      drive(0, sda_pad_i, 8);
      drive(0, bits[i], 8);
      drive(1, bits[i], 8);
    end
    drive(1, 1, 8);
    settle();
    chkn("xfer sta", n_sta, 1);
    chkn("xfer rising", n_rise, 9);
    chkn("xfer faling", n_fall, 9);
    chkn("xfer sto", n_sto, 1);
    chk1("xfer idle", bus_busy, 1'b0);

    // Repeated START while busy.
    clr();
    drive(1, 0, 8);
    drive(0, 0, 8);
    drive(0, 1, 8);
    drive(1, 1, 8);
    drive(1, 0, 8);
    settle();
    chkn("rsta sta", n_sta, 2);
    chkn("rsta sto", n_sto, 0);
    chk1("rsta busy", bus_busy, 1'b1);
    drive(1, 1, 8);
    settle();
    chkn("rsta final sto", n_sto, 1);

    // SCL held low past the timeout.
    to_val = 16'd100;
    clr();
    drive(1, 0, 8);
    drive(0, 0, 150);
    settle();
    chkn("timeout count", n_to, 1);
    chkn("timeout delay", c_to - c_sclf, 100);
    chk1("timeout busy", bus_busy, 1'b0);
    drive(1, 0, 8);
    drive(1, 1, 8);
    settle();
    to_val = '0;

    // Arbitration loss only when the local master owns the bus.
    mst_active = 1'b1;
    clr();
    drive(1, 0, 8);
    drive(0, 0, 8);
    drive(1, 0, 8);
    settle();
    chkn("arb count", n_arb, 1);
    chkn("arb with rise", c_arb - c_rise, 0);
    mst_active = 1'b0;
    drive(0, 0, 8);
    drive(1, 0, 8);
    settle();
    chkn("arb slave none", n_arb, 1);
    chkn("arb slave rises", n_rise, 2);
    drive(1, 1, 8);
    settle();

    // filt_len = 0: one-cycle pulse passes with SYNC_STG + 1 latency.
    filt_len = 4'd0;
    clr();
    drive(1, 0, 1);
    t0 = t_set;
    drive(1, 1, 8);
    settle();
    chkn("f0 sda latency", c_sdaf - t0, 3);
    chkn("f0 sta", n_sta, 1);
    chkn("f0 sto", n_sto, 1);
    filt_len = 4'd3;

    // Disabled block still filters the lines but emits nothing.
    cr_en = 1'b0;
    scl_o = 1'b0; sda_o = 1'b0;
    clr();
    drive(1, 0, 8);
    drive(0, 0, 8);
    drive(1, 0, 8);
    drive(1, 1, 8);
    settle();
    chkn("dis strobes", n_sta + n_sto + n_rise + n_fall, 0);
    chkn("dis busy cycles", n_busy, 0);
    chkn("dis scl tracks", n_sclf, 1);
    chkn("dis sda tracks", n_sdaf, 1);
    chk1("dis scl_pad_oe", scl_pad_oe, 1'b0);
    chk1("dis sda_pad_oe", sda_pad_oe, 1'b0);
    cr_en = 1'b1;
    @(posedge clk); #4;
    chk1("en scl_pad_oe", scl_pad_oe, 1'b1);
    chk1("en sda_pad_oe", sda_pad_oe, 1'b1);
    @(negedge clk);
    scl_o = 1'b1; sda_o = 1'b1;

    // Reset in the middle of a transfer.
    clr();
    drive(1, 0, 8);
    drive(0, 0, 8);
    settle();
    chk1("mid busy before", bus_busy, 1'b1);
    rstn = 1'b0;
    scl_pad_i = 1'b1;
    sda_pad_i = 1'b1;
    #1;
    chk1("mid rst busy", bus_busy, 1'b0);
    chk1("mid rst scl_i", scl_i, 1'b1);
    chk1("mid rst sda_i", sda_i, 1'b1);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    drive(1, 1, 10);
    settle();
    chkn("mid rst no sto", n_sto, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
